// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the memory array and mem_port_arbiter.
// Signal names keep the legacy port names so existing connections map one-to-one.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              if_req_i;
  logic [31:0]       if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [31:0]       if_rdata_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [1:0]        d_size_i;
  logic              d_unsigned_i;
  logic [31:0]       d_addr_i;
  logic [31:0]       d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [31:0]       d_rdata_o;
  logic              d_err_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_req_i, d_we_i, d_size_i, d_unsigned_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  // Core requesters plus memory array side
  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_req_i, d_we_i, d_size_i, d_unsigned_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data-priority with a fetch anti-starvation guard,
// byte-lane steering for stores and extract/extend for loads (1-cycle read latency).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;

  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

  logic [3:0]  r_run;
  logic [1:0]  r_owner;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;
  logic        r_err;
  logic        r_we;

  logic        w_fetch_turn;
  logic        w_d_gnt;
  logic        w_if_gnt;
  logic [1:0]  w_off;
  logic        w_mis;
  logic        w_d_mem;
  logic        w_mem_we;
  logic [3:0]  w_be_st;
  logic [31:0] w_wdata_st;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;
  logic        w_unused;

  // ---------------------------------------------------------------- arbitration
  assign w_fetch_turn = bus.if_req_i && (r_run == RUN_MAX);
  assign w_d_gnt      = rst_ni && bus.d_req_i && !w_fetch_turn;
  assign w_if_gnt     = rst_ni && bus.if_req_i && !w_d_gnt;

  assign bus.d_gnt_o  = w_d_gnt;
  assign bus.if_gnt_o = w_if_gnt;

  // Run length of data grants that a waiting fetch has had to sit through
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run <= '0;
    end else if (!bus.if_req_i || w_if_gnt) begin
      r_run <= '0;
    end else if (w_d_gnt && (r_run != RUN_MAX)) begin
      r_run <= r_run + 4'd1;
    end
  end

  // ---------------------------------------------------------------- request decode
  assign w_off = bus.d_addr_i[1:0];

  always_comb begin
    w_mis = 1'b0;
    case (bus.d_size_i)
      2'b00:   w_mis = 1'b0;
      2'b01:   w_mis = w_off[0];
      2'b10:   w_mis = (w_off != 2'b00);
      default: w_mis = 1'b1;
    endcase
  end

  always_comb begin
    w_be_st    = 4'b1111;
    w_wdata_st = bus.d_wdata_i;
    case (bus.d_size_i)
      2'b00: begin
        w_be_st    = 4'b0001 << w_off;
        w_wdata_st = {4{bus.d_wdata_i[7:0]}};
      end
      2'b01: begin
        w_be_st    = 4'b0011 << w_off;
        w_wdata_st = {2{bus.d_wdata_i[15:0]}};
      end
      default: begin
        w_be_st    = 4'b1111;
        w_wdata_st = bus.d_wdata_i;
      end
    endcase
  end

  // ---------------------------------------------------------------- memory side
  assign w_d_mem  = w_d_gnt && !w_mis;
  assign w_mem_we = w_d_mem && bus.d_we_i;

  assign bus.mem_req_o   = w_if_gnt || w_d_mem;
  assign bus.mem_we_o    = w_mem_we;
  assign bus.mem_be_o    = w_mem_we ? w_be_st : 4'b1111;
  assign bus.mem_addr_o  = w_d_gnt ? bus.d_addr_i[ADDR_W+1:2] : bus.if_addr_i[ADDR_W+1:2];
  assign bus.mem_wdata_o = w_mem_we ? w_wdata_st : '0;

  // ---------------------------------------------------------------- response stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner <= OWN_NONE;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_off   <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
    end else if (w_if_gnt) begin
      r_owner <= OWN_IF;
      r_size  <= 2'b10;
      r_uns   <= 1'b0;
      r_off   <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
    end else if (w_d_gnt) begin
      r_owner <= OWN_DATA;
      r_size  <= bus.d_size_i;
      r_uns   <= bus.d_unsigned_i;
      r_off   <= w_off;
      r_err   <= w_mis;
      r_we    <= bus.d_we_i;
    end else begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
    end
  end

  always_comb begin
    w_ld_byte = bus.mem_rdata_i[7:0];
    case (r_off)
      2'd0:    w_ld_byte = bus.mem_rdata_i[7:0];
      2'd1:    w_ld_byte = bus.mem_rdata_i[15:8];
      2'd2:    w_ld_byte = bus.mem_rdata_i[23:16];
      default: w_ld_byte = bus.mem_rdata_i[31:24];
    endcase
    w_ld_half = r_off[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];

    w_ld_data = bus.mem_rdata_i;
    case (r_size)
      2'b00:   w_ld_data = r_uns ? {24'h0, w_ld_byte} : {{24{w_ld_byte[7]}}, w_ld_byte};
      2'b01:   w_ld_data = r_uns ? {16'h0, w_ld_half} : {{16{w_ld_half[15]}}, w_ld_half};
      default: w_ld_data = bus.mem_rdata_i;
    endcase
  end

  assign bus.if_rvalid_o = (r_owner == OWN_IF);
  assign bus.if_rdata_o  = (r_owner == OWN_IF) ? bus.mem_rdata_i : '0;
  assign bus.d_rvalid_o  = (r_owner == OWN_DATA);
  assign bus.d_err_o     = (r_owner == OWN_DATA) && r_err;
  assign bus.d_rdata_o   = ((r_owner == OWN_DATA) && !r_err && !r_we) ? w_ld_data : '0;

  assign w_unused = ^{bus.if_addr_i[31:ADDR_W+2], bus.if_addr_i[1:0], bus.d_addr_i[31:ADDR_W+2]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed stimulus for mem_port_arbiter with a response scoreboard fed at grant
// time from a behavioural memory and load/misalignment reference functions.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 12;

  typedef struct {
    bit          is_if;
    logic [31:0] rdata;
    bit          err;
  } rsp_t;

  logic clk;
  logic rst_n;

  logic [31:0] mem_arr [4096];
  rsp_t        exp_q [$];

  int unsigned n_checks;
  int unsigned n_fail;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .MAX_DATA_RUN (4)
  ) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] off);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    if (sz == 2'b00) return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    if (sz == 2'b01) return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    return w;
  endfunction

  // Behavioural memory array with 1-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_req_o === 1'b1) begin
      if (bus.mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be_o[b]) mem_arr[bus.mem_addr_o][8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
      end else begin
        bus.mem_rdata_i <= mem_arr[bus.mem_addr_o];
      end
    end
  end

  // Scoreboard: pop the response owed this cycle, then push for the current grant
  always @(negedge clk) begin
    rsp_t e;
    if (!rst_n) begin
      exp_q.delete();
      check_eq("rst_if_rvalid", 32'(bus.if_rvalid_o), 32'd0);
      check_eq("rst_d_rvalid",  32'(bus.d_rvalid_o),  32'd0);
      check_eq("rst_d_err",     32'(bus.d_err_o),     32'd0);
      check_eq("rst_if_rdata",  bus.if_rdata_o,       32'd0);
      check_eq("rst_d_rdata",   bus.d_rdata_o,        32'd0);
      check_eq("rst_gnts",      32'({bus.if_gnt_o, bus.d_gnt_o}), 32'd0);
      check_eq("rst_mem_req",   32'(bus.mem_req_o),   32'd0);
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.is_if) begin
          check_eq("sb_if_rvalid", 32'(bus.if_rvalid_o), 32'd1);
          check_eq("sb_d_rvalid0", 32'(bus.d_rvalid_o),  32'd0);
          check_eq("sb_if_rdata",  bus.if_rdata_o,       e.rdata);
        end else begin
          check_eq("sb_d_rvalid",  32'(bus.d_rvalid_o),  32'd1);
          check_eq("sb_if_rvalid0", 32'(bus.if_rvalid_o), 32'd0);
          check_eq("sb_d_err",     32'(bus.d_err_o),     32'(e.err));
          check_eq("sb_d_rdata",   bus.d_rdata_o,        e.rdata);
        end
      end else begin
        check_eq("sb_idle_rvalid", 32'({bus.if_rvalid_o, bus.d_rvalid_o}), 32'd0);
      end

      check_eq("one_gnt", 32'(bus.if_gnt_o && bus.d_gnt_o), 32'd0);
      if (bus.if_gnt_o) begin
        exp_q.push_back('{is_if: 1'b1, rdata: mem_arr[bus.if_addr_i[ADDR_W+1:2]], err: 1'b0});
      end else if (bus.d_gnt_o) begin
        if (ref_mis(bus.d_size_i, bus.d_addr_i))
          exp_q.push_back('{is_if: 1'b0, rdata: 32'h0, err: 1'b1});
        else if (bus.d_we_i)
          exp_q.push_back('{is_if: 1'b0, rdata: 32'h0, err: 1'b0});
        else
          exp_q.push_back('{is_if: 1'b0,
                            rdata: ref_load(mem_arr[bus.d_addr_i[ADDR_W+1:2]], bus.d_size_i,
                                            bus.d_unsigned_i, bus.d_addr_i[1:0]),
                            err: 1'b0});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit want_if);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!(want_if ? bus.if_gnt_o : bus.d_gnt_o) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_data(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd);
    bus.d_req_i      = 1'b1;
    bus.d_we_i       = we;
    bus.d_size_i     = sz;
    bus.d_unsigned_i = uns;
    bus.d_addr_i     = addr;
    bus.d_wdata_i    = wd;
  endtask

  bit pat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 4096; i++) mem_arr[i] = 32'h0;
    mem_arr[2]    = 32'h0000_0013;
    mem_arr[4]    = 32'hCAFE_0004;
    mem_arr[8]    = 32'h1122_3344;
    mem_arr[16]   = 32'h8001_1234;

    rst_n            = 1'b0;
    bus.if_req_i     = 1'b0;
    bus.if_addr_i    = '0;
    drive_data(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    bus.d_req_i      = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-operation: fetch granted, reset before the response is sampled
    step();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0010;
    wait_gnt(1'b1);
    check_eq("t1_mem_addr", 32'(bus.mem_addr_o), 32'h4);
    check_eq("t1_mem_req",  32'(bus.mem_req_o),  32'd1);
    step();
    bus.if_req_i = 1'b0;
    rst_n        = 1'b0;
    drive_data(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    check_eq("t1_if_rvalid", 32'(bus.if_rvalid_o), 32'd0);
    check_eq("t1_d_gnt_gated", 32'(bus.d_gnt_o), 32'd0);
    step();
    bus.d_req_i = 1'b0;
    rst_n       = 1'b1;
    @(negedge clk);
    check_eq("t1_idle_mem_req", 32'(bus.mem_req_o), 32'd0);
    check_eq("t1_post_rvalid",  32'(bus.if_rvalid_o), 32'd0);

    // Single fetch
    step();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0008;
    wait_gnt(1'b1);
    check_eq("t2_if_gnt",   32'(bus.if_gnt_o),   32'd1);
    check_eq("t2_mem_addr", 32'(bus.mem_addr_o), 32'h2);
    check_eq("t2_mem_we",   32'(bus.mem_we_o),   32'd0);
    step();
    bus.if_req_i = 1'b0;
    @(negedge clk);
    check_eq("t2_if_rvalid", 32'(bus.if_rvalid_o), 32'd1);
    check_eq("t2_if_rdata",  bus.if_rdata_o,       32'h0000_0013);

    // Continuous contention: fetch forced in after four data grants
    step();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0008;
    drive_data(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq($sformatf("t3_d_gnt_%0d", i),  32'(bus.d_gnt_o),  32'(pat[i]));
      check_eq($sformatf("t3_if_gnt_%0d", i), 32'(bus.if_gnt_o), 32'(!pat[i]));
      step();
    end
    bus.if_req_i = 1'b0;
    bus.d_req_i  = 1'b0;
    @(negedge clk);

    // Store byte with lane replication
    step();
    drive_data(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h1234_56A5);
    wait_gnt(1'b0);
    check_eq("t4_mem_we",    32'(bus.mem_we_o),   32'd1);
    check_eq("t4_mem_be",    32'(bus.mem_be_o),   32'b1000);
    check_eq("t4_mem_addr",  32'(bus.mem_addr_o), 32'h40);
    check_eq("t4_mem_wdata", bus.mem_wdata_o,     32'hA5A5_A5A5);
    step();
    bus.d_req_i = 1'b0;
    @(negedge clk);
    check_eq("t4_d_rvalid", 32'(bus.d_rvalid_o), 32'd1);
    check_eq("t4_d_err",    32'(bus.d_err_o),    32'd0);
    check_eq("t4_mem_word", mem_arr[64],         32'hA500_0000);

    // Half loads, signed and unsigned
    for (int u = 0; u < 2; u++) begin
      step();
      drive_data(1'b0, 2'b01, 1'(u), 32'h0000_0042, 32'h0);
      wait_gnt(1'b0);
      check_eq("t5_mem_be", 32'(bus.mem_be_o), 32'hF);
      check_eq("t5_mem_we", 32'(bus.mem_we_o), 32'd0);
      step();
      bus.d_req_i = 1'b0;
      @(negedge clk);
      check_eq("t5_d_rdata", bus.d_rdata_o, (u == 0) ? 32'hFFFF_8001 : 32'h0000_8001);
    end

    // Signed byte load at top lane, then half store and read-back
    step();
    drive_data(1'b0, 2'b00, 1'b0, 32'h0000_0043, 32'h0);
    wait_gnt(1'b0);
    step();
    bus.d_req_i = 1'b0;
    @(negedge clk);
    check_eq("t5_byte_rdata", bus.d_rdata_o, 32'hFFFF_FF80);
    step();
    drive_data(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_BEEF);
    wait_gnt(1'b0);
    check_eq("t5_half_be",    32'(bus.mem_be_o), 32'b1100);
    check_eq("t5_half_wdata", bus.mem_wdata_o,   32'hBEEF_BEEF);
    step();
    drive_data(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0);
    wait_gnt(1'b0);
    step();
    bus.d_req_i = 1'b0;
    @(negedge clk);
    check_eq("t5_word_rdata", bus.d_rdata_o, 32'hBEEF_3344);

    // Misaligned word with a concurrent fetch
    step();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0008;
    drive_data(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
    wait_gnt(1'b0);
    check_eq("t6_d_gnt",   32'(bus.d_gnt_o),   32'd1);
    check_eq("t6_if_gnt",  32'(bus.if_gnt_o),  32'd0);
    check_eq("t6_mem_req", 32'(bus.mem_req_o), 32'd0);
    step();
    bus.d_req_i = 1'b0;
    @(negedge clk);
    check_eq("t6_if_gnt_next", 32'(bus.if_gnt_o),  32'd1);
    check_eq("t6_d_rvalid",    32'(bus.d_rvalid_o), 32'd1);
    check_eq("t6_d_err",       32'(bus.d_err_o),    32'd1);
    check_eq("t6_d_rdata",     bus.d_rdata_o,       32'h0);
    step();
    bus.if_req_i = 1'b0;
    drive_data(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF);
    wait_gnt(1'b0);
    check_eq("t6_rsv_mem_req", 32'(bus.mem_req_o), 32'd0);
    step();
    drive_data(1'b0, 2'b01, 1'b1, 32'h0000_0041, 32'h0);
    wait_gnt(1'b0);
    check_eq("t6_half_mem_req", 32'(bus.mem_req_o), 32'd0);
    step();
    bus.d_req_i = 1'b0;
    @(negedge clk);
    check_eq("t6_half_err", 32'(bus.d_err_o), 32'd1);

    step();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous main memory between the instruction-fetch requester and the load/store data requester.
- The memory has 1-cycle read latency.
- Arbitrates with data priority plus a fetch anti-starvation guard.
- Generates byte enables and write-data lane steering from access size, and extracts/extends load data.
- Flags misaligned data accesses without touching memory; sits between the core's fetch/LSU stages and the memory array.

Parameters:
ADDR_W, 12, word-address width of memory (4096 x 32-bit words).
MAX_DATA_RUN, 4, max consecutive data grants while fetch is waiting before fetch is forced a grant (1..15).

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_ni  input  1  asynchronous active-low reset
if_req_i  input  1  fetch request, held until if_gnt_o
if_addr_i  input  32  fetch byte address; bits [1:0] ignored
if_gnt_o  output  1  fetch accepted this cycle (combinational)
if_rvalid_o  output  1  fetch data valid (cycle after grant)
if_rdata_o  output  32  fetched instruction word
d_req_i  input  1  data request, held until d_gnt_o
d_we_i  input  1  1 = store, 0 = load
d_size_i  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
d_unsigned_i  input  1  load zero-extend when 1, sign-extend when 0
d_addr_i  input  32  data byte address
d_wdata_i  input  32  store data, right-justified
d_gnt_o  output  1  data accepted this cycle (combinational)
d_rvalid_o  output  1  data response valid (load data or store ack)
d_rdata_o  output  32  extended load data; 0 for stores and errors
d_err_o  output  1  misaligned/illegal; qualified by d_rvalid_o
mem_req_o  output  1  memory access this cycle
mem_we_o  output  1  memory write
mem_be_o  output  4  byte enables
mem_addr_o  output  ADDR_W  word address = byte address [ADDR_W+1:2]
mem_wdata_o  output  32  lane-steered store data
mem_rdata_i  input  32  memory read data, valid cycle after mem_req_o

Behaviour:
- Reset (rst_ni low, async): run counter = 0, response owner = NONE, if_rvalid_o = d_rvalid_o = d_err_o = 0. rdata outputs = 0. Any in-flight response is dropped. Grants are combinational on requests and are gated low while rst_ni is low.
- Arbitration each cycle:
  - Data wins unless if_req_i is high and run counter == MAX_DATA_RUN.
  - Exactly one grant per cycle. Losers hold their request.
- Run counter:
  - Increments on a data grant while if_req_i is high, saturating at MAX_DATA_RUN.
  - Clears on a fetch grant, or on any cycle if_req_i is low.
- Misalignment: size 01 with addr[0]=1, size 10 with addr[1:0]!=0, or size 11.
  - Request is still granted, with mem_req_o = 0.
  - Next cycle: d_rvalid_o = 1, d_err_o = 1, d_rdata_o = 0.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0]
  - word: 1111
  - Loads drive mem_be_o = 1111, mem_we_o = 0.
- Store data lanes: byte replicated into all 4 lanes; half replicated into both halves; word passed through.
- Response register (1 stage): records owner (IF/DATA), size, unsigned flag, addr[1:0] and error on grant.
  - Next cycle, the owner's rvalid is 1 for exactly one cycle.
  - IF: if_rdata_o = mem_rdata_i.
  - Data load: select the byte/half at the offset, then sign/zero-extend to 32.
  - Store: rvalid is an ack, rdata = 0.
- Throughput: back-to-back grants every cycle are allowed; a response and a new grant may coincide.
- A requester dropping its req without a grant is legal: no effect.
- The mem_*_o outputs are combinational from the winner.

Test Plan:
1. Reset mid-operation: grant a fetch at 0x10, assert rst_ni=0 before the response -> if_rvalid_o stays 0, all outputs 0; after release, idle mem_req_o=0.
2. Single fetch at 0x0000_0008 with memory word 2 = 0x0000_0013 -> if_gnt_o=1, mem_addr_o=2, next cycle if_rvalid_o=1, if_rdata_o=0x0000_0013.
3. Continuous data and fetch requests, MAX_DATA_RUN=4 -> grant pattern D,D,D,D,I,D,D,D,D,I; counter clears after the fetch grant.
4. Store byte 0xA5 to 0x0000_0103 -> mem_we_o=1, mem_be_o=1000, mem_addr_o=0x40, mem_wdata_o=0xA5A5_A5A5; next cycle d_rvalid_o=1, d_err_o=0.
5. Load half signed at 0x0000_0042 with word = 0x8001_1234 -> d_rdata_o=0xFFFF_8001. Same access with d_unsigned_i=1 -> 0x0000_8001.
6. Load word at 0x0000_0006 -> d_gnt_o=1, mem_req_o=0; next cycle d_rvalid_o=1, d_err_o=1, d_rdata_o=0. A fetch requested in the same cycle is granted the following cycle.
